// File: rtl/_ram8_if.sv
// Bus bundle for the 8-word register bank: write data, load strobe, shared address, read data.
interface _ram8_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] in;
  logic             load;
  logic [2:0]       address;
  logic [WIDTH-1:0] out;

  modport master (
    output in,
    output load,
    output address,
    input  out
  );

  modport slave (
    input  in,
    input  load,
    input  address,
    output out
  );
endinterface

// File: rtl/_ram8.sv
// 8 x WIDTH register bank: writes land one cycle after load, reads are combinational.
// No handshake; the read mux shows the old word until the write edge (no bypass).
module _ram8 #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input logic    clk,
  input logic    rst_n,
  _ram8_if.slave bus
);

  logic [7:0]       load_en;
  logic [WIDTH-1:0] word [8];
  logic [WIDTH-1:0] lo_word;
  logic [WIDTH-1:0] hi_word;

  // One-hot demux of the load strobe by address.
  always_comb begin
    load_en = 8'h00;
    load_en[bus.address] = bus.load;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        word[i] <= RESET_VAL;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (load_en[i]) begin
          word[i] <= bus.in;
        end
      end
    end
  end

  // Two 4-way halves, then address[2] picks word0-3 or word4-7.
  always_comb begin
    lo_word = word[{1'b0, bus.address[1:0]}];
    hi_word = word[{1'b1, bus.address[1:0]}];
  end

  assign bus.out = bus.address[2] ? hi_word : lo_word;

endmodule

// File: tb/tb__ram8.sv
// Directed bench for _ram8: reset, fill, isolation, read-during-write, hold, async reset.
module tb__ram8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [15:0] mdl [8];

  _ram8_if #(.WIDTH(16)) bus ();

  _ram8 #(
    .WIDTH     (16),
    .RESET_VAL (16'h0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] exp);
    checks++;
    assert (bus.out === exp)
    else begin
      errors++;
      $error("FAIL %s addr=%0d got=%h exp=%h", tag, bus.address, bus.out, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [15:0] exp);
    bus.address = a;
    #1;
    chk(tag, exp);
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.address = a;
    bus.in      = d;
    bus.load    = 1'b1;
    @(posedge clk);
    #1;
    bus.load    = 1'b0;
  endtask

  task automatic rd_all(input string tag);
    for (int k = 0; k < 8; k++) begin
      rd(tag, 3'(k), mdl[k]);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    bus.in      = 16'h0;
    bus.load    = 1'b0;
    bus.address = 3'd0;
    for (int k = 0; k < 8; k++) mdl[k] = 16'h0000;

    // 1. Reset: every address reads zero while reset is held.
    #1;
    for (int k = 0; k < 8; k++) rd("reset", 3'(k), 16'h0000);

    @(negedge clk);
    rst_n = 1'b1;

    // 2. Fill and read back; first write after release is honoured.
    for (int k = 0; k < 8; k++) begin
      wr(3'(k), 16'h1111 * 16'(k + 1));
      mdl[k] = 16'h1111 * 16'(k + 1);
    end
    rd("fill0", 3'd0, 16'h1111);
    rd("fill7", 3'd7, 16'h8888);
    rd_all("fill");

    // 3. Isolation: only word5 changes.
    wr(3'd5, 16'hBEEF);
    mdl[5] = 16'hBEEF;
    rd("iso5", 3'd5, 16'hBEEF);
    rd_all("iso");

    // 4. Read-during-write: old value before the edge, new value after.
    @(negedge clk);
    bus.address = 3'd2;
    bus.in      = 16'hA5A5;
    bus.load    = 1'b1;
    #1;
    chk("rdw_before", 16'h3333);
    @(posedge clk);
    #1;
    bus.load = 1'b0;
    chk("rdw_after", 16'hA5A5);
    mdl[2] = 16'hA5A5;

    // 5. load=0 hold under random in/address activity.
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      bus.in      = 16'($urandom);
      bus.address = 3'($urandom_range(0, 7));
      bus.load    = 1'b0;
    end
    @(posedge clk);
    #1;
    rd_all("hold");

    // 6. Async reset between edges, then reset-vs-load, then recovery.
    @(posedge clk);
    #2;
    bus.address = 3'd6;
    #1;
    chk("pre_arst", 16'h7777);
    rst_n = 1'b0;
    #1;
    chk("arst_now", 16'h0000);
    for (int k = 0; k < 8; k++) mdl[k] = 16'h0000;
    rd_all("arst");

    @(negedge clk);
    bus.address = 3'd3;
    bus.in      = 16'h1234;
    bus.load    = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_wins", 16'h0000);
    @(negedge clk);
    bus.load = 1'b0;
    rst_n    = 1'b1;
    #1;
    rd_all("post_rel");

    wr(3'd4, 16'h4444);
    mdl[4] = 16'h4444;
    rd("rewrite4", 3'd4, 16'h4444);
    rd_all("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
